// File: rtl/rtc_rd_seq.sv
// rtc_rd_seq: single-register read sequencer for a multiplexed-AD-bus RTC, all outputs registered.
module rtc_rd_seq #(
    parameter int unsigned T_PH = 10
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic [7:0] addr,
    input  logic [7:0] ad_in,
    output logic [7:0] ad_out,
    output logic       ad_oe,
    output logic       cs_n,
    output logic       rd_n,
    output logic       wr_n,
    output logic       a_d,
    output logic [7:0] dato,
    output logic       dato_vld,
    output logic       busy
);
    typedef enum logic [2:0] {IDLE, ADR_WR, ADR_HLD, TURN, RD_LOW, RELEASE, DONE} state_t;

    state_t     r_state;
    state_t     w_nxt;
    logic       w_last;
    logic [7:0] r_cnt;
    logic [7:0] r_cap;
    logic [7:0] r_ad_out;
    logic [7:0] r_dato;
    logic       r_ad_oe, r_cs_n, r_rd_n, r_wr_n, r_a_d, r_vld, r_busy;

    assign w_last = r_cnt == 8'd0;
    // timed phases advance in enum order; RELEASE + 1 is DONE
    assign w_nxt  = (r_state == IDLE) ? (start ? ADR_WR : IDLE) :
                    (r_state == DONE) ? IDLE :
                    w_last ? state_t'(r_state + 3'd1) : r_state;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state  <= IDLE;
            r_cnt    <= 8'd0;
            r_cap    <= 8'h00;
            r_ad_out <= 8'h00;
            r_dato   <= 8'h00;
            r_ad_oe  <= 1'b0;
            r_cs_n   <= 1'b1;
            r_rd_n   <= 1'b1;
            r_wr_n   <= 1'b1;
            r_a_d    <= 1'b0;
            r_vld    <= 1'b0;
            r_busy   <= 1'b0;
        end else begin
            r_state  <= w_nxt;
            r_cnt    <= (w_nxt != r_state) ? 8'(T_PH - 1) : r_cnt - {7'd0, !w_last};
            r_ad_out <= (r_state == IDLE && start) ? addr : r_ad_out;
            // staged capture keeps dato untouched if the read is aborted before DONE
            r_cap    <= (r_state == RD_LOW && w_last) ? ad_in : r_cap;
            r_dato   <= (w_nxt == DONE) ? r_cap : r_dato;
            r_vld    <= w_nxt == DONE;
            r_busy   <= w_nxt != IDLE;
            r_cs_n   <= !(w_nxt inside {ADR_WR, ADR_HLD, TURN, RD_LOW});
            r_wr_n   <= w_nxt != ADR_WR;
            r_rd_n   <= w_nxt != RD_LOW;
            r_a_d    <= w_nxt inside {TURN, RD_LOW};
            r_ad_oe  <= w_nxt inside {ADR_WR, ADR_HLD};
        end
    end

    assign ad_out   = r_ad_out;
    assign ad_oe    = r_ad_oe;
    assign cs_n     = r_cs_n;
    assign rd_n     = r_rd_n;
    assign wr_n     = r_wr_n;
    assign a_d      = r_a_d;
    assign dato     = r_dato;
    assign dato_vld = r_vld;
    assign busy     = r_busy;
endmodule

// File: doc/rtc_rd_seq.md
RTC_RD_SEQ -- requirements
Module: rtc_rd_seq

Interface
REQ-001 SHALL have parameter T_PH, default 10, clk cycles per bus phase (legal range 1..255).
REQ-002 SHALL have port clk  input  1  single system clock; all state updates on rising edge.
REQ-003 SHALL have port reset  input  1  asynchronous, active-low reset; reset=0 forces reset state immediately.
REQ-004 SHALL have port start  input  1  read request, sampled only in IDLE.
REQ-005 SHALL have port addr  input  8  RTC register address to read (e.g. seconds register).
REQ-006 SHALL have port ad_in  input  8  value sensed on the multiplexed RTC AD bus.
REQ-007 SHALL have port ad_out  output  8  value driven onto the AD bus when ad_oe=1.
REQ-008 SHALL have port ad_oe  output  1  AD bus output enable (1 = block drives bus).
REQ-009 SHALL have ports cs_n, rd_n, wr_n  output  1 each  active-low RTC chip select, read and write strobes.
REQ-010 SHALL have port a_d  output  1  address/data select (0 = address phase, 1 = data phase).
REQ-011 SHALL have port dato  output  8  last captured read data, held until the next capture.
REQ-012 SHALL have port dato_vld  output  1  one-cycle pulse when dato updates; feeds the EN of the per-field time register.
REQ-013 SHALL have port busy  output  1  high from the cycle after start acceptance until return to IDLE.

Function
REQ-014 SHALL implement FSM states IDLE, ADR_WR, ADR_HLD, TURN, RD_LOW, RELEASE, DONE.
REQ-015 SHALL use an 8-bit phase counter: loaded with T_PH-1 on each state entry, decremented each cycle, state advances when counter=0, so every non-IDLE/DONE state lasts exactly T_PH cycles.
REQ-016 IDLE: cs_n=1, rd_n=1, wr_n=1, a_d=0, ad_oe=0, busy=0; start=1 -> latch addr into an internal register, go to ADR_WR.
REQ-017 ADR_WR: cs_n=0, wr_n=0, a_d=0, ad_oe=1, ad_out=latched addr.
REQ-018 ADR_HLD: wr_n=1, cs_n=0, ad_oe=1, ad_out held (address hold after strobe).
REQ-019 TURN: ad_oe=0, a_d=1, cs_n=0, all strobes high (bus turnaround, no contention).
REQ-020 RD_LOW: rd_n=0, cs_n=0, a_d=1, ad_oe=0; on the final cycle (counter=0) ad_in SHALL be registered into dato.
REQ-021 RELEASE: rd_n=1, cs_n=1, a_d=0, ad_oe=0.
REQ-022 DONE: lasts one cycle, dato_vld=1, then IDLE; dato_vld SHALL be 0 in every other state.
REQ-023 Total latency SHALL be 5*T_PH+1 cycles from the start-sampling edge to dato_vld.
REQ-024 start asserted while busy SHALL be ignored (no queuing); addr changes after acceptance SHALL NOT affect the cycle in progress.
REQ-025 start held high continuously SHALL launch back-to-back reads, each new read beginning from IDLE after DONE (one IDLE cycle minimum between reads).
REQ-026 ad_oe and rd_n=0 SHALL never be simultaneously active; wr_n and rd_n SHALL never both be 0.
REQ-027 All outputs SHALL be registered (no combinational path from inputs to outputs).

Reset
REQ-028 reset=0 SHALL asynchronously force: state IDLE, counter 0, cs_n=1, rd_n=1, wr_n=1, a_d=0, ad_oe=0, ad_out=0x00, dato=0x00, dato_vld=0, busy=0.
REQ-029 Reset mid-cycle SHALL abort the transaction without updating dato and without a dato_vld pulse; after release, operation resumes only on a new start.

Verification
REQ-030 T_PH=10, addr=0x21, ad_in=0x45 during RD_LOW, start pulse -> ad_out=0x21 with wr_n=0 for 10 cycles, rd_n=0 for 10 cycles, dato=0x45 and one dato_vld pulse 51 cycles after start.
REQ-031 T_PH=1 -> each phase exactly one cycle, dato_vld 6 cycles after start, no overlap of ad_oe with rd_n=0.
REQ-032 start pulsed again during RD_LOW with addr=0x22 -> ignored; only one dato_vld, dato from first read.
REQ-033 reset=0 asserted during RD_LOW, ad_in=0x99 -> all strobes high immediately, dato stays 0x00, no dato_vld.
REQ-034 start held high, ad_in=0x12 then 0x34 -> two reads, two dato_vld pulses separated by 5*T_PH+2 cycles, dato 0x12 then 0x34.
REQ-035 ad_in toggled outside the RD_LOW final cycle -> dato reflects only the value present on that final cycle.
